// File: rtl/two_bit_multiplier.sv
// Pipelined 2x2-bit unsigned multiplier built from AND partial products and two
// half adders. LATENCY selects a one- or two-stage pipeline; out_comb is the raw product.
module two_bit_multiplier #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       in_valid,
  output logic [3:0] out,
  output logic       out_valid,
  output logic [3:0] out_comb
);

  // Valid-only streaming: in_valid=1 means a/b are taken on that rising edge
  // (there is no ready, so the block never stalls); out_valid=1 marks the single
  // cycle in which out carries a fresh product. Gaps pass through unchanged.

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic p00, p01, p10, p11, c1;
    p00 = x[0] & y[0];
    p01 = x[0] & y[1];
    p10 = x[1] & y[0];
    p11 = x[1] & y[1];
    c1  = p01 & p10;
    return {p11 & c1, p11 ^ c1, p01 ^ p10, p00};
  endfunction

  assign out_comb = mul2(a, b);

  logic       fin_valid;
  logic [3:0] fin_prod;

  // Any value other than 1 builds the two-stage variant.
  if (LATENCY == 1) begin : g_lat1
    assign fin_valid = in_valid;
    assign fin_prod  = out_comb;
  end else begin : g_lat2
    logic [1:0] a_q, a_d;
    logic [1:0] b_q, b_d;
    logic       v_q, v_d;

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      v_d = in_valid;
      if (in_valid) begin
        a_d = a;
        b_d = b;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= 2'b00;
        b_q <= 2'b00;
        v_q <= 1'b0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        v_q <= v_d;
      end
    end

    assign fin_valid = v_q;
    assign fin_prod  = mul2(a_q, b_q);
  end

  logic [3:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  // Output register holds its last product across bubbles.
  always_comb begin
    out_d       = out_q;
    out_valid_d = fin_valid;
    if (fin_valid) begin
      out_d = fin_prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_two_bit_multiplier.sv
// Directed bench for two_bit_multiplier: runs LATENCY=1 and LATENCY=2 instances
// side by side on the same stimulus with hand-computed expected values.
module tb_two_bit_multiplier;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [1:0] a, b;
  logic       in_valid;
  logic [3:0] out1, out2, comb1, comb2;
  logic       ov1, ov2;

  int n_checks;
  int n_errors;

  // Hand-computed products indexed by {a,b}.
  logic [3:0] prod_tab [16] = '{4'd0, 4'd0, 4'd0, 4'd0,
                                4'd0, 4'd1, 4'd2, 4'd3,
                                4'd0, 4'd2, 4'd4, 4'd6,
                                4'd0, 4'd3, 4'd6, 4'd9};

  // Bubble sequence: (2,2),gap,(3,1),gap,gap,(1,3),gap,gap
  logic       bub_v   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] bub_a   [8] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  logic [1:0] bub_b   [8] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
  // Expected {out_valid,out} after each edge.
  logic [4:0] bub_e1  [8] = '{5'h14, 5'h04, 5'h13, 5'h03, 5'h03, 5'h13, 5'h03, 5'h03};
  logic [4:0] bub_e2  [8] = '{5'h09, 5'h14, 5'h04, 5'h13, 5'h03, 5'h03, 5'h13, 5'h03};

  two_bit_multiplier #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .out(out1), .out_valid(ov1), .out_comb(comb1)
  );

  two_bit_multiplier #(.LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .out(out2), .out_valid(ov2), .out_comb(comb2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Checking
  task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [4:0] exp1, input logic [4:0] exp2);
    check_val({tag, "_l1"}, {ov1, out1}, exp1);
    check_val({tag, "_l2"}, {ov2, out2}, exp2);
  endtask

  // Drivers
  task automatic drive(input logic v, input logic [1:0] da, input logic [1:0] db);
    in_valid = v;
    if (v) begin
      a = da;
      b = db;
    end else begin
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] idx;
    n_checks = 0;
    n_errors = 0;
    clk_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 2'd3;
    b        = 2'd2;
    #2;

    // Reset state with clock stopped, and out_comb alive during reset
    check_both("reset", 5'h00, 5'h00);
    check_val("comb_in_reset", {1'b0, comb2}, 5'd6);

    // Combinational sweep, clock stopped
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      a = idx[3:2];
      b = idx[1:0];
      #1;
      check_val("comb_l1", {1'b0, comb1}, {1'b0, prod_tab[idx]});
      check_val("comb_l2", {1'b0, comb2}, {1'b0, prod_tab[idx]});
    end
    check_both("reset_after_sweep", 5'h00, 5'h00);

    clk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Exhaustive back-to-back, then two idle cycles
    for (int i = 0; i < 18; i++) begin
      idx = 4'(i);
      if (i < 16) drive(1'b1, idx[3:2], idx[1:0]);
      else drive(1'b0, 2'd0, 2'd0);
      tick();
      if (i < 16) check_val("exh_l1", {ov1, out1}, {1'b1, prod_tab[idx]});
      else        check_val("exh_l1", {ov1, out1}, 5'h09);
      if (i == 0)       check_val("exh_l2", {ov2, out2}, 5'h00);
      else if (i <= 16) check_val("exh_l2", {ov2, out2}, {1'b1, prod_tab[4'(i - 1)]});
      else              check_val("exh_l2", {ov2, out2}, 5'h09);
    end

    // Bubbles, junk operands during gaps
    for (int k = 0; k < 8; k++) begin
      drive(bub_v[k], bub_a[k], bub_b[k]);
      tick();
      check_both("bubble", bub_e1[k], bub_e2[k]);
    end

    // Reset mid-stream: (3,3) captured, reset asserted between edges
    drive(1'b1, 2'd3, 2'd3);
    tick();
    check_both("pre_reset", 5'h19, 5'h03);
    drive(1'b0, 2'd0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async_reset", 5'h00, 5'h00);
    tick();
    check_both("in_reset", 5'h00, 5'h00);

    // Post-reset: release just after an edge, (2,1) on the first edge
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 2'd1);
    tick();
    check_both("post_reset_c1", 5'h12, 5'h00);
    drive(1'b0, 2'd0, 2'd0);
    tick();
    check_both("post_reset_c2", 5'h02, 5'h12);
    tick();
    check_both("post_reset_c3", 5'h02, 5'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bounded run time
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
